// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and duty of an asynchronous PWM input.
// Ports: CLK, RST (async, active-high), EN, PWM_IN -> PERIOD_CNT, HIGH_CNT, DUTY, VALID, STUCK, OVERRUN.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 16'hFFFF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             PWM_IN,
  output logic [CNT_W-1:0] PERIOD_CNT,
  output logic [CNT_W-1:0] HIGH_CNT,
  output logic [7:0]       DUTY,
  output logic             VALID,
  output logic             STUCK,
  output logic             OVERRUN
);

  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             sync_d;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] per_inc;
  logic [CNT_W-1:0] high_inc;
  logic [CNT_W-1:0] hold_per;
  logic [CNT_W-1:0] hold_high;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_nx;
  logic [CNT_W:0]   rem_sh;
  logic [7:0]       quo;
  logic [7:0]       quo_nx;
  logic [3:0]       step;
  logic             q_top;
  logic             rise;
  logic             busy;
  logic             cap;
  logic             tmo_hit;
  logic             ge;
  logic             hi_ge;

  assign rise     = sync2 & ~sync_d;
  assign busy     = (step != 4'd0);
  assign cap      = (state == MEAS) & rise;
  // Timeout fires on the cycle the period counter steps onto TIMEOUT;
  // a coincident edge wins.
  assign tmo_hit  = (state != IDLE) & ~rise & ~STUCK
                  & (per_cnt == TMO_M1);
  assign per_inc  = (per_cnt == TMO) ? per_cnt : per_cnt + ONE;
  assign high_inc = (sync2 && high_cnt != TMO) ? high_cnt + ONE
                                               : high_cnt;

  // high <= period, so the load step resolves the 2^8 quotient bit and
  // the 8 iterations produce the fractional bits.
  assign hi_ge  = (hold_high >= hold_per);
  assign rem_sh = {rem, 1'b0};
  assign ge     = (rem_sh >= {1'b0, hold_per});
  assign rem_nx = ge ? CNT_W'(rem_sh - {1'b0, hold_per})
                     : rem_sh[CNT_W-1:0];
  assign quo_nx = {quo[6:0], ge};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= PWM_IN;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      per_cnt    <= '0;
      high_cnt   <= '0;
      hold_per   <= '0;
      hold_high  <= '0;
      rem        <= '0;
      quo        <= '0;
      q_top      <= 1'b0;
      step       <= 4'd0;
      PERIOD_CNT <= '0;
      HIGH_CNT   <= '0;
      DUTY       <= '0;
      VALID      <= 1'b0;
      STUCK      <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (!EN) begin
        state    <= IDLE;
        per_cnt  <= '0;
        high_cnt <= '0;
        step     <= 4'd0;
        STUCK    <= 1'b0;
        OVERRUN  <= 1'b0;
      end else begin
        if (step == 4'd1) begin
          q_top <= hi_ge;
          rem   <= hi_ge ? hold_high - hold_per : hold_high;
          quo   <= '0;
          step  <= 4'd2;
        end else if (busy) begin
          rem <= rem_nx;
          quo <= quo_nx;
          if (step == 4'd9) begin
            step <= 4'd0;
            // A capture on the final step supersedes this result.
            if (!cap) begin
              VALID      <= 1'b1;
              PERIOD_CNT <= hold_per;
              HIGH_CNT   <= hold_high;
              DUTY       <= q_top ? 8'hFF : quo_nx;
            end
          end else begin
            step <= step + 4'd1;
          end
        end

        unique case (state)
          IDLE: begin
            state    <= ARM;
            per_cnt  <= '0;
            high_cnt <= '0;
          end
          ARM: begin
            high_cnt <= '0;
            if (rise) begin
              state    <= MEAS;
              STUCK    <= 1'b0;
              per_cnt  <= ONE;
              high_cnt <= ONE;
            end else begin
              per_cnt <= per_inc;
            end
          end
          MEAS: begin
            if (rise) begin
              hold_per  <= per_cnt;
              hold_high <= high_cnt;
              step      <= 4'd1;
              per_cnt   <= ONE;
              high_cnt  <= ONE;
              if (busy) OVERRUN <= 1'b1;
            end else begin
              per_cnt  <= per_inc;
              high_cnt <= high_inc;
            end
          end
          default: state <= IDLE;
        endcase

        // Stuck input: report once, then wait in ARM for a fresh edge.
        if (tmo_hit) begin
          state      <= ARM;
          STUCK      <= 1'b1;
          step       <= 4'd0;
          per_cnt    <= TMO;
          high_cnt   <= '0;
          VALID      <= 1'b1;
          PERIOD_CNT <= '0;
          HIGH_CNT   <= '0;
          DUTY       <= {8{sync2}};
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: table-driven and scoreboard checks for pwm_capture.
// Drives PWM waveforms, predicts every VALID (cycle and values) and compares.
module tb_pwm_capture;

  localparam int CNT_W = 16;
  localparam int TMOUT = 300;
  localparam int LAT   = 12;

  logic             CLK = 1'b0;
  logic             RST;
  logic             EN;
  logic             PWM_IN;
  logic [CNT_W-1:0] PERIOD_CNT;
  logic [CNT_W-1:0] HIGH_CNT;
  logic [7:0]       DUTY;
  logic             VALID;
  logic             STUCK;
  logic             OVERRUN;

  pwm_capture #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TMOUT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .PWM_IN    (PWM_IN),
    .PERIOD_CNT(PERIOD_CNT),
    .HIGH_CNT  (HIGH_CNT),
    .DUTY      (DUTY),
    .VALID     (VALID),
    .STUCK     (STUCK),
    .OVERRUN   (OVERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int per;
    int high;
    int duty;
    int cyc;
  } exp_t;

  typedef struct {
    int h;
    int l;
    int n;
    int ep;
    int eh;
    int ed;
  } row_t;

  exp_t sb[$];
  exp_t prev;
  bit   have_prev;
  bit   push_on;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   t0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (VALID) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got VALID with P=%0d H=%0d D=%0d (cycle %0d)",
                 PERIOD_CNT, HIGH_CNT, DUTY, cyc);
      end else begin
        e = sb.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("period_cnt", int'(PERIOD_CNT), e.per);
        chk("high_cnt", int'(HIGH_CNT), e.high);
        chk("duty", int'(DUTY), e.duty);
      end
    end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      chk("valid_missing_cycle", cyc, e.cyc);
    end
  end

  task automatic period(int h, int l, int ep, int eh, int ed);
    if (have_prev && push_on)
      sb.push_back('{prev.per, prev.high, prev.duty, cyc + LAT});
    PWM_IN = 1'b1;
    repeat (h) @(negedge CLK);
    PWM_IN = 1'b0;
    repeat (l) @(negedge CLK);
    prev      = '{ep, eh, ed, 0};
    have_prev = 1'b1;
  endtask

  task automatic close_rise();
    period(1, 20, 0, 0, 0);
    have_prev = 1'b0;
  endtask

  task automatic restart();
    EN     = 1'b0;
    PWM_IN = 1'b0;
    repeat (5) @(negedge CLK);
    EN        = 1'b1;
    have_prev = 1'b0;
    push_on   = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_period"}, int'(PERIOD_CNT), 0);
    chk({tag, "_high"}, int'(HIGH_CNT), 0);
    chk({tag, "_duty"}, int'(DUTY), 0);
    chk({tag, "_valid"}, int'(VALID), 0);
    chk({tag, "_stuck"}, int'(STUCK), 0);
    chk({tag, "_overrun"}, int'(OVERRUN), 0);
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[8];
    rows[0] = '{64, 192, 3, 256, 64, 64};
    rows[1] = '{30, 10, 3, 40, 30, 192};
    rows[2] = '{10, 30, 3, 40, 10, 64};
    rows[3] = '{20, 20, 2, 40, 20, 128};
    rows[4] = '{1, 9, 3, 10, 1, 25};
    rows[5] = '{9, 1, 3, 10, 9, 230};
    rows[6] = '{5, 7, 3, 12, 5, 106};
    rows[7] = '{100, 3, 2, 103, 100, 248};

    RST       = 1'b1;
    EN        = 1'b0;
    PWM_IN    = 1'b0;
    have_prev = 1'b0;
    push_on   = 1'b1;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b0;

    for (int r = 0; r < 8; r++) begin
      restart();
      for (int p = 0; p < rows[r].n; p++)
        period(rows[r].h, rows[r].l, rows[r].ep, rows[r].eh, rows[r].ed);
      close_rise();
      repeat (20) @(negedge CLK);
      chk($sformatf("row%0d_sb_empty", r), sb.size(), 0);
      chk($sformatf("row%0d_overrun", r), int'(OVERRUN), 0);
    end

    // Duty change without re-arming.
    restart();
    for (int p = 0; p < 3; p++) period(30, 10, 40, 30, 192);
    for (int p = 0; p < 2; p++) period(10, 30, 40, 10, 64);
    close_rise();
    repeat (20) @(negedge CLK);
    chk("switch_sb_empty", sb.size(), 0);

    // Period 3: every capture restarts the divider; only the last reports.
    restart();
    push_on = 1'b0;
    for (int p = 0; p < 6; p++) period(1, 2, 3, 1, 85);
    push_on = 1'b1;
    close_rise();
    repeat (20) @(negedge CLK);
    chk("ovr_overrun", int'(OVERRUN), 1);
    chk("ovr_sb_empty", sb.size(), 0);

    // Input stuck high after a capture edge.
    restart();
    for (int p = 0; p < 2; p++) period(30, 10, 40, 30, 192);
    t0 = cyc;
    sb.push_back('{40, 30, 192, t0 + LAT});
    sb.push_back('{0, 0, 255, t0 + TMOUT + 2});
    have_prev = 1'b0;
    PWM_IN    = 1'b1;
    repeat (TMOUT + 1) @(negedge CLK);
    chk("stuck_before", int'(STUCK), 0);
    @(negedge CLK);
    chk("stuck_set", int'(STUCK), 1);
    repeat (40) @(negedge CLK);
    chk("stuck_held", int'(STUCK), 1);
    PWM_IN = 1'b0;
    repeat (10) @(negedge CLK);
    period(20, 20, 40, 20, 128);
    chk("stuck_cleared", int'(STUCK), 0);
    period(20, 20, 40, 20, 128);
    close_rise();
    repeat (20) @(negedge CLK);
    chk("stuck_sb_empty", sb.size(), 0);

    // EN dropped 4 cycles after a capture.
    restart();
    for (int p = 0; p < 2; p++) period(30, 10, 40, 30, 192);
    have_prev = 1'b0;
    PWM_IN    = 1'b1;
    repeat (7) @(negedge CLK);
    EN     = 1'b0;
    PWM_IN = 1'b0;
    repeat (20) @(negedge CLK);
    chk("endrop_period", int'(PERIOD_CNT), 40);
    chk("endrop_high", int'(HIGH_CNT), 30);
    chk("endrop_duty", int'(DUTY), 192);
    chk("endrop_stuck", int'(STUCK), 0);
    EN = 1'b1;
    repeat (3) @(negedge CLK);
    period(10, 30, 40, 10, 64);
    period(10, 30, 40, 10, 64);
    close_rise();
    repeat (20) @(negedge CLK);
    chk("endrop_sb_empty", sb.size(), 0);

    // Reset in the middle of a division.
    restart();
    for (int p = 0; p < 2; p++) period(30, 10, 40, 30, 192);
    have_prev = 1'b0;
    PWM_IN    = 1'b1;
    repeat (6) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk_zero("midrst");
    for (int i = 0; i < 4; i++) begin
      PWM_IN = ~PWM_IN;
      @(negedge CLK);
    end
    PWM_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    period(20, 20, 40, 20, 128);
    period(20, 20, 40, 20, 128);
    close_rise();
    repeat (20) @(negedge CLK);
    chk("midrst_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
